mips_cpu_control_fsm: RTL and testbench

- Multicycle MIPS control unit that owns its own state register.
- Generates every datapath control strobe per cycle from opcode/fncode plus a memory wait handshake.
- Supersedes purely combinational decode: variable-length instruction sequences, memory stalls, halt-on-PC-zero and graceful illegal-opcode trap.
- Sits between instruction register / PC logic and the shared ALU, register file and memory port.

---
 rtl/mips_cpu_pkg.sv | 61 ++++++
 rtl/mips_cpu_instr_class.sv | 38 +++
 rtl/mips_cpu_control_fsm.sv | 186 ++++++++++++++++++
 tb/tb_mips_cpu_control_fsm.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// States, opcodes, function codes, ALU and mux select encodings.
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM    = 4'd3,
        S_WB     = 4'd4,
        S_HALT   = 4'd5,
        S_TRAP   = 4'd6
    } state_t;

    typedef enum logic [3:0] {
        C_RARITH, C_IMM, C_LUI, C_LOAD, C_STORE,
        C_BRANCH, C_JUMP, C_JUMPREG, C_ILLEGAL
    } iclass_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2,
        ALU_LUI   = 2'd3
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_RS     = 2'd3;

    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_4     = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

endpackage

// File: rtl/mips_cpu_instr_class.sv
// Opcode/function decode into an instruction class.
// Jump forms fold into ILLEGAL when jumps are not built in.
module mips_cpu_instr_class
    import mips_cpu_pkg::*;
#(
    parameter int HAS_JUMPS = 1
) (
    input  logic [5:0] opcode_i,
    input  logic [5:0] fncode_i,
    output iclass_t    class_o
);

    localparam iclass_t JCLS  = (HAS_JUMPS != 0) ? C_JUMP : C_ILLEGAL;
    localparam iclass_t JRCLS = (HAS_JUMPS != 0) ? C_JUMPREG : C_ILLEGAL;

    // classify the instruction held in IR
    always_comb begin
        class_o = C_ILLEGAL;
        unique case (opcode_i)
            OP_RTYPE: begin
                unique case (fncode_i)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_SLT, FN_SLTU: class_o = C_RARITH;
                    FN_JR, FN_JALR:          class_o = JRCLS;
                    default:                 class_o = C_ILLEGAL;
                endcase
            end
            OP_ADDIU:       class_o = C_IMM;
            OP_LUI:         class_o = C_LUI;
            OP_LW:          class_o = C_LOAD;
            OP_SW:          class_o = C_STORE;
            OP_BEQ, OP_BNE: class_o = C_BRANCH;
            OP_J, OP_JAL:   class_o = JCLS;
            default:        class_o = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// Multicycle MIPS control FSM with memory stall, halt and trap handling.
// Strobes are forced low while reset is asserted.
module mips_cpu_control_fsm
    import mips_cpu_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 0,
    parameter int HAS_JUMPS   = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         fncode,
    input  logic               waitrequest,
    input  logic               pc_is_zero,
    output logic [1:0]         regdst,
    output logic               regwrite,
    output logic               iord,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               pcwritecond,
    output logic               branch_ne,
    output logic [1:0]         pcsource,
    output logic               memread,
    output logic               memwrite,
    output logic               memtoreg,
    output logic [ALUOP_W-1:0] aluop,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [3:0]         state_o,
    output logic               active,
    output logic               trap
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    iclass_t        cls;
    aluop_t         alu_e;
    logic           mem_wait;
    logic           timeout;

    mips_cpu_instr_class #(.HAS_JUMPS(HAS_JUMPS)) u_class (
        .opcode_i (opcode),
        .fncode_i (fncode),
        .class_o  (cls)
    );

    assign mem_wait = waitrequest &&
                      (state_q == S_FETCH || state_q == S_MEM);
    assign timeout  = (MEM_TIMEOUT > 0) && mem_wait &&
                      (cnt_q == CW'(MEM_TIMEOUT - 1));

    assign state_o = state_q;
    assign active  = !(state_q == S_HALT || state_q == S_TRAP);
    assign trap    = (state_q == S_TRAP);
    assign aluop   = ALUOP_W'(alu_e);

    // state and stall counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next-state sequencing and stall counting
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (pc_is_zero)        state_d = S_HALT;
                else if (timeout)      state_d = S_TRAP;
                else if (!waitrequest) state_d = S_DECODE;
            end
            S_DECODE: state_d = (cls == C_ILLEGAL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                unique case (cls)
                    C_RARITH, C_IMM, C_LUI: state_d = S_WB;
                    C_LOAD, C_STORE:        state_d = S_MEM;
                    default:                state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (timeout)           state_d = S_TRAP;
                else if (!waitrequest) state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        if (state_d != state_q) cnt_d = '0;
        else if (mem_wait)      cnt_d = cnt_q + CW'(1);
        else                    cnt_d = cnt_q;
    end

    // per-state datapath strobes
    always_comb begin
        regdst      = RD_RT;
        regwrite    = 1'b0;
        iord        = 1'b0;
        irwrite     = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        branch_ne   = 1'b0;
        pcsource    = PCS_ALU;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        alu_e       = ALU_ADD;
        alusrca     = 1'b0;
        alusrcb     = SRCB_B;
        if (reset_n) begin
            unique case (state_q)
                S_FETCH: begin
                    if (!pc_is_zero) begin
                        memread = 1'b1;
                        alusrcb = SRCB_4;
                        if (!waitrequest) begin
                            irwrite = 1'b1;
                            pcwrite = 1'b1;
                        end
                    end
                end
                S_DECODE: alusrcb = SRCB_IMMSH;
                S_EXEC: begin
                    unique case (cls)
                        C_RARITH: begin
                            alusrca = 1'b1;
                            alu_e   = ALU_FUNCT;
                        end
                        C_IMM, C_LOAD, C_STORE: begin
                            alusrca = 1'b1;
                            alusrcb = SRCB_IMM;
                        end
                        C_LUI: begin
                            alu_e   = ALU_LUI;
                            alusrcb = SRCB_IMM;
                        end
                        C_BRANCH: begin
                            alusrca     = 1'b1;
                            alu_e       = ALU_SUB;
                            pcwritecond = 1'b1;
                            pcsource    = PCS_ALUOUT;
                            branch_ne   = (opcode == OP_BNE);
                        end
                        C_JUMP: begin
                            pcwrite  = 1'b1;
                            pcsource = PCS_JUMP;
                            if (opcode == OP_JAL) begin
                                regwrite = 1'b1;
                                regdst   = RD_RA;
                            end
                        end
                        C_JUMPREG: begin
                            pcwrite  = 1'b1;
                            pcsource = PCS_RS;
                            if (fncode == FN_JALR) begin
                                regwrite = 1'b1;
                                regdst   = RD_RD;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    iord     = 1'b1;
                    memread  = (cls == C_LOAD);
                    memwrite = (cls == C_STORE);
                end
                S_WB: begin
                    regwrite = 1'b1;
                    regdst   = (opcode == OP_RTYPE) ? RD_RD : RD_RT;
                    memtoreg = (cls == C_LOAD);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// Bench for the multicycle MIPS control FSM.
// Directed vectors, corner sequences and a randomized instruction stream.
module tb_mips_cpu_control_fsm;

  typedef struct packed {
    logic [1:0] regdst;
    logic       regwrite, iord, irwrite, pcwrite, pcwritecond, branch_ne;
    logic [1:0] pcsource;
    logic       memread, memwrite, memtoreg;
    logic [3:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
  } ctl_t;

  typedef struct {
    bit         rst;
    logic       w, pz;
    logic [5:0] op, fn;
    logic [3:0] st;
    ctl_t       c;
    logic       act, tr;
  } vec_t;

  typedef struct {
    logic       w;
    logic [3:0] st;
    ctl_t       c;
  } exp_t;

  typedef enum int {
    K_R, K_ADDIU, K_LUI, K_LW, K_SW, K_BEQ, K_BNE,
    K_J, K_JAL, K_JR, K_JALR
  } kind_t;

  typedef struct {
    logic [5:0] op, fn;
    kind_t      k;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, rst2_n, waitrequest, pc_is_zero;
  logic [5:0] opcode, fncode;

  logic [1:0] regdst, pcsource, alusrcb;
  logic       regwrite, iord, irwrite, pcwrite, pcwritecond, branch_ne;
  logic       memread, memwrite, memtoreg, alusrca, active, trap;
  logic [3:0] aluop, state_o;

  logic [1:0] t_regdst, t_pcsource, t_alusrcb;
  logic       t_regwrite, t_iord, t_irwrite, t_pcwrite, t_pcwritecond;
  logic       t_branch_ne, t_memread, t_memwrite, t_memtoreg, t_alusrca;
  logic       t_active, t_trap;
  logic [3:0] t_aluop, t_state_o;

  mips_cpu_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .fncode(fncode),
    .waitrequest(waitrequest), .pc_is_zero(pc_is_zero),
    .regdst(regdst), .regwrite(regwrite), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .branch_ne(branch_ne),
    .pcsource(pcsource), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .aluop(aluop), .alusrca(alusrca),
    .alusrcb(alusrcb), .state_o(state_o), .active(active), .trap(trap)
  );

  mips_cpu_control_fsm #(.MEM_TIMEOUT(8), .HAS_JUMPS(0)) dut2 (
    .clk(clk), .reset_n(rst2_n), .opcode(opcode), .fncode(fncode),
    .waitrequest(waitrequest), .pc_is_zero(pc_is_zero),
    .regdst(t_regdst), .regwrite(t_regwrite), .iord(t_iord),
    .irwrite(t_irwrite), .pcwrite(t_pcwrite),
    .pcwritecond(t_pcwritecond), .branch_ne(t_branch_ne),
    .pcsource(t_pcsource), .memread(t_memread), .memwrite(t_memwrite),
    .memtoreg(t_memtoreg), .aluop(t_aluop), .alusrca(t_alusrca),
    .alusrcb(t_alusrcb), .state_o(t_state_o), .active(t_active),
    .trap(t_trap)
  );

  ctl_t a;
  assign a = {regdst, regwrite, iord, irwrite, pcwrite, pcwritecond,
              branch_ne, pcsource, memread, memwrite, memtoreg, aluop,
              alusrca, alusrcb};

  int npass = 0;
  int ntot  = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  function automatic ctl_t cw(int rd, int rw, int io, int ir, int pw,
                              int pc, int bn, int ps, int mr, int mw,
                              int mt, int ao, int sa, int sb);
    ctl_t c;
    c.regdst = 2'(rd);     c.regwrite = 1'(rw);  c.iord = 1'(io);
    c.irwrite = 1'(ir);    c.pcwrite = 1'(pw);   c.pcwritecond = 1'(pc);
    c.branch_ne = 1'(bn);  c.pcsource = 2'(ps);  c.memread = 1'(mr);
    c.memwrite = 1'(mw);   c.memtoreg = 1'(mt);  c.aluop = 4'(ao);
    c.alusrca = 1'(sa);    c.alusrcb = 2'(sb);
    return c;
  endfunction

  // frequently used control words
  ctl_t c_fstall, c_fgo, c_dec, c_zero, c_addr;

  task automatic step_chk(string nm, logic w, logic pz, logic [3:0] st,
                          ctl_t c, logic act, logic tr);
    waitrequest = w;
    pc_is_zero  = pz;
    #1;
    chk({nm, ".state"}, 32'(state_o), 32'(st));
    chk({nm, ".ctl"}, 32'(a), 32'(c));
    chk({nm, ".act_trap"}, 32'({active, trap}), 32'({act, tr}));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rst2_n = 1'b0;
    waitrequest = 1'b0;
    pc_is_zero = 1'b0;
    #1;
    chk("rst.state", 32'(state_o), 32'd0);
    chk("rst.ctl", 32'(a), 32'd0);
    chk("rst.act_trap", 32'({active, trap}), 32'b10);
    chk("rst2.state", 32'(t_state_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rst2_n = 1'b1;
  endtask

  // reference model: expected per-cycle trace of one instruction
  exp_t q[$];

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic plan(kind_t k, int wf, int wm);
    ctl_t ex;
    for (int i = 0; i < wf; i++) q.push_back('{1'b1, 4'd0, c_fstall});
    q.push_back('{1'b0, 4'd0, c_fgo});
    q.push_back('{rb(), 4'd1, c_dec});
    case (k)
      K_R:     ex = cw(0,0,0,0,0,0,0,0,0,0,0,2,1,0);
      K_ADDIU: ex = c_addr;
      K_LUI:   ex = cw(0,0,0,0,0,0,0,0,0,0,0,3,0,2);
      K_LW:    ex = c_addr;
      K_SW:    ex = c_addr;
      K_BEQ:   ex = cw(0,0,0,0,0,1,0,1,0,0,0,1,1,0);
      K_BNE:   ex = cw(0,0,0,0,0,1,1,1,0,0,0,1,1,0);
      K_J:     ex = cw(0,0,0,0,1,0,0,2,0,0,0,0,0,0);
      K_JAL:   ex = cw(2,1,0,0,1,0,0,2,0,0,0,0,0,0);
      K_JR:    ex = cw(0,0,0,0,1,0,0,3,0,0,0,0,0,0);
      default: ex = cw(1,1,0,0,1,0,0,3,0,0,0,0,0,0);
    endcase
    q.push_back('{rb(), 4'd2, ex});
    if (k == K_LW || k == K_SW) begin
      ex = (k == K_LW) ? cw(0,0,1,0,0,0,0,0,1,0,0,0,0,0)
                       : cw(0,0,1,0,0,0,0,0,0,1,0,0,0,0);
      for (int i = 0; i < wm; i++) q.push_back('{1'b1, 4'd3, ex});
      q.push_back('{1'b0, 4'd3, ex});
    end
    case (k)
      K_R:          q.push_back('{rb(), 4'd4, cw(1,1,0,0,0,0,0,0,0,0,0,0,0,0)});
      K_ADDIU, K_LUI:
                    q.push_back('{rb(), 4'd4, cw(0,1,0,0,0,0,0,0,0,0,0,0,0,0)});
      K_LW:         q.push_back('{rb(), 4'd4, cw(0,1,0,0,0,0,0,0,0,0,1,0,0,0)});
      default: ;
    endcase
  endtask

  task automatic run_plan(string nm);
    exp_t e;
    int n = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      step_chk($sformatf("%s.c%0d", nm, n), e.w, 1'b0, e.st, e.c, 1'b1, 1'b0);
      n++;
    end
  endtask

  vec_t vt[$];
  ins_t il[$];

  initial begin
    reset_n = 1'b0;
    rst2_n = 1'b0;
    opcode = '0;
    fncode = '0;
    waitrequest = 1'b0;
    pc_is_zero = 1'b0;
    c_fstall = cw(0,0,0,0,0,0,0,0,1,0,0,0,0,1);
    c_fgo    = cw(0,0,0,1,1,0,0,0,1,0,0,0,0,1);
    c_dec    = cw(0,0,0,0,0,0,0,0,0,0,0,0,0,3);
    c_zero   = '0;
    c_addr   = cw(0,0,0,0,0,0,0,0,0,0,0,0,1,2);
    @(negedge clk);

    // ADDU, BNE, illegal opcode, illegal R-type function
    vt.push_back('{1, 0, 0, 6'h00, 6'h21, 4'd0, c_fgo, 1, 0});
    vt.push_back('{0, 1, 0, 6'h00, 6'h21, 4'd1, c_dec, 1, 0});
    vt.push_back('{0, 0, 0, 6'h00, 6'h21, 4'd2,
                   cw(0,0,0,0,0,0,0,0,0,0,0,2,1,0), 1, 0});
    vt.push_back('{0, 1, 0, 6'h00, 6'h21, 4'd4,
                   cw(1,1,0,0,0,0,0,0,0,0,0,0,0,0), 1, 0});
    vt.push_back('{0, 1, 0, 6'h00, 6'h21, 4'd0, c_fstall, 1, 0});
    vt.push_back('{1, 0, 0, 6'h05, 6'h00, 4'd0, c_fgo, 1, 0});
    vt.push_back('{0, 0, 0, 6'h05, 6'h00, 4'd1, c_dec, 1, 0});
    vt.push_back('{0, 0, 0, 6'h05, 6'h00, 4'd2,
                   cw(0,0,0,0,0,1,1,1,0,0,0,1,1,0), 1, 0});
    vt.push_back('{0, 1, 0, 6'h05, 6'h00, 4'd0, c_fstall, 1, 0});
    vt.push_back('{1, 0, 0, 6'h3F, 6'h00, 4'd0, c_fgo, 1, 0});
    vt.push_back('{0, 0, 0, 6'h3F, 6'h00, 4'd1, c_dec, 1, 0});
    vt.push_back('{0, 0, 0, 6'h3F, 6'h00, 4'd6, c_zero, 0, 1});
    vt.push_back('{0, 1, 1, 6'h00, 6'h21, 4'd6, c_zero, 0, 1});
    vt.push_back('{1, 0, 0, 6'h00, 6'h20, 4'd0, c_fgo, 1, 0});
    vt.push_back('{0, 0, 0, 6'h00, 6'h20, 4'd1, c_dec, 1, 0});
    vt.push_back('{0, 0, 0, 6'h00, 6'h20, 4'd6, c_zero, 0, 1});

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      opcode = vt[i].op;
      fncode = vt[i].fn;
      step_chk($sformatf("vec%0d", i), vt[i].w, vt[i].pz, vt[i].st,
               vt[i].c, vt[i].act, vt[i].tr);
    end

    // LW with three MEM stall cycles
    do_reset();
    opcode = 6'h23;
    fncode = 6'h00;
    plan(K_LW, 0, 3);
    chk("lw.cycles", 32'(q.size()), 32'd8);
    run_plan("lw");

    // pc_is_zero beats waitrequest, then HALT is terminal
    do_reset();
    waitrequest = 1'b1;
    pc_is_zero = 1'b1;
    #1;
    chk("halt.fetch_memread", 32'(memread), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      opcode = 6'($urandom);
      step_chk($sformatf("halt%0d", i), rb(), rb(), 4'd5, c_zero, 1'b0, 1'b0);
    end

    // FETCH stall timeout on the MEM_TIMEOUT=8 instance
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      waitrequest = 1'b1;
      #1;
      chk($sformatf("tmo%0d.state", i), 32'(t_state_o),
          (i < 8) ? 32'd0 : 32'd6);
      chk($sformatf("tmo%0d.trap", i), 32'(t_trap), (i < 8) ? 32'd0 : 32'd1);
      chk($sformatf("tmo%0d.dflt", i), 32'(state_o), 32'd0);
      @(negedge clk);
    end

    // jumps trap when not built in
    do_reset();
    opcode = 6'h02;
    step_chk("nojmp.f", 1'b0, 1'b0, 4'd0, c_fgo, 1'b1, 1'b0);
    step_chk("nojmp.d", 1'b0, 1'b0, 4'd1, c_dec, 1'b1, 1'b0);
    #1;
    chk("nojmp.t_state", 32'(t_state_o), 32'd6);
    chk("nojmp.t_trap", 32'(t_trap), 32'd1);
    chk("nojmp.state", 32'(state_o), 32'd2);
    @(negedge clk);

    // reset in the middle of a stalled store
    do_reset();
    opcode = 6'h2B;
    step_chk("swr.f", 1'b0, 1'b0, 4'd0, c_fgo, 1'b1, 1'b0);
    step_chk("swr.d", 1'b0, 1'b0, 4'd1, c_dec, 1'b1, 1'b0);
    step_chk("swr.e", 1'b0, 1'b0, 4'd2, c_addr, 1'b1, 1'b0);
    waitrequest = 1'b1;
    #1;
    chk("swr.memwrite_on", 32'(memwrite), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("swr.memwrite_off", 32'(memwrite), 32'd0);
    chk("swr.state", 32'(state_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step_chk("swr.post", 1'b1, 1'b0, 4'd0, c_fstall, 1'b1, 1'b0);

    // randomized instruction stream
    il.push_back('{6'h00, 6'h21, K_R});
    il.push_back('{6'h00, 6'h23, K_R});
    il.push_back('{6'h00, 6'h24, K_R});
    il.push_back('{6'h00, 6'h25, K_R});
    il.push_back('{6'h00, 6'h26, K_R});
    il.push_back('{6'h00, 6'h2A, K_R});
    il.push_back('{6'h00, 6'h2B, K_R});
    il.push_back('{6'h09, 6'h00, K_ADDIU});
    il.push_back('{6'h0F, 6'h00, K_LUI});
    il.push_back('{6'h23, 6'h00, K_LW});
    il.push_back('{6'h2B, 6'h00, K_SW});
    il.push_back('{6'h04, 6'h00, K_BEQ});
    il.push_back('{6'h05, 6'h00, K_BNE});
    il.push_back('{6'h02, 6'h00, K_J});
    il.push_back('{6'h03, 6'h00, K_JAL});
    il.push_back('{6'h00, 6'h08, K_JR});
    il.push_back('{6'h00, 6'h09, K_JALR});

    do_reset();
    for (int n = 0; n < 60; n++) begin
      int idx;
      idx = $urandom_range(0, il.size() - 1);
      opcode = il[idx].op;
      fncode = il[idx].fn;
      plan(il[idx].k, $urandom_range(0, 2), $urandom_range(0, 3));
      run_plan($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
